// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_defs: shared fetch-controller state encodings and constants
package pc_defs;
  typedef enum logic [1:0] {BOOT, REQ, HOLD, FAULT} state_t;
  localparam int WORD_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// next_pc_sel: redirect priority (jr > jump > branch) and target arithmetic
module next_pc_sel
  import pc_defs::*;
(
  input  logic [31:0] cur_pc,
  input  logic [31:0] branch_offset,
  input  logic [31:0] br_pc_plus4,
  input  logic        branch_taken,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic        redir,
  output logic        misalign,
  output logic [31:0] target,
  output logic [31:0] seq_pc
);
  always_comb begin
    misalign = jr_en && (jr_target[1:0] != 2'b00);
    redir = jr_en ? !misalign : (jump_en || branch_taken);
    target = jr_en ? jr_target :
             jump_en ? {br_pc_plus4[31:28], jump_index, 2'b00} :
             br_pc_plus4 + branch_offset;
    seq_pc = cur_pc + 32'(WORD_BYTES);
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC, req/ack instruction fetch, redirect squash
module pc_fetch_ctrl
  import pc_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] branch_offset,
  input  logic [31:0] br_pc_plus4,
  input  logic        branch_taken,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        align_fault
);
  state_t      state, state_nx;
  logic        redir, misalign, ack, pend_valid;
  logic [31:0] target, seq_pc, pend_addr;

  next_pc_sel u_sel (
    .cur_pc(if_addr),
    .branch_offset(branch_offset),
    .br_pc_plus4(br_pc_plus4),
    .branch_taken(branch_taken),
    .jump_en(jump_en),
    .jump_index(jump_index),
    .jr_en(jr_en),
    .jr_target(jr_target),
    .redir(redir),
    .misalign(misalign),
    .target(target),
    .seq_pc(seq_pc)
  );

  assign ack = if_req && if_ack;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_nx;

  always_comb begin
    if_req = (state == REQ);
    state_nx = misalign ? FAULT :
               (state == BOOT) ? REQ :
               (state == REQ && ack && stall) ? HOLD :
               (state == HOLD && !stall) ? REQ : state;
  end

  // With no request outstanding a redirect lands in if_addr directly, so nothing is squashed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      if_addr <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_pc <= RESET_PC;
      align_fault <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr <= RESET_PC;
    end else begin
      fetch_valid <= 1'b0;
      if (misalign) begin
        align_fault <= 1'b1;
        pend_valid <= 1'b0;
      end else if (ack) begin
        fetch_valid <= !(redir || pend_valid);
        fetch_pc <= if_addr;
        if_addr <= redir ? target : pend_valid ? pend_addr : seq_pc;
        pend_valid <= 1'b0;
      end else if (redir && if_req) begin
        pend_valid <= 1'b1;
        pend_addr <= target;
      end else if (redir && state != FAULT) begin
        if_addr <= target;
      end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed stimulus with a fetch_valid/fetch_pc scoreboard
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, rst_n2 = 1'b0;
  logic [31:0] branch_offset = '0, br_pc_plus4 = '0, jr_target = '0;
  logic        branch_taken = 1'b0, jump_en = 1'b0, jr_en = 1'b0, stall = 1'b0, if_ack = 1'b0;
  logic [25:0] jump_index = '0;
  logic        if_req, fetch_valid, align_fault, if_req2, fetch_valid2, align_fault2;
  logic [31:0] if_addr, fetch_pc, if_addr2, fetch_pc2;
  logic [31:0] q[$];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .branch_offset(branch_offset), .br_pc_plus4(br_pc_plus4),
    .branch_taken(branch_taken), .jump_en(jump_en), .jump_index(jump_index), .jr_en(jr_en),
    .jr_target(jr_target), .stall(stall), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .align_fault(align_fault)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n2), .branch_offset(branch_offset), .br_pc_plus4(br_pc_plus4),
    .branch_taken(branch_taken), .jump_en(jump_en), .jump_index(jump_index), .jr_en(jr_en),
    .jr_target(jr_target), .stall(stall), .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack),
    .fetch_valid(fetch_valid2), .fetch_pc(fetch_pc2), .align_fault(align_fault2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst_n && fetch_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_fetch: got pc %h expected no valid word", fetch_pc);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        if (fetch_pc !== e) begin
          fails++;
          $display("FAIL fetch_pc: got %h expected %h", fetch_pc, e);
        end
      end
    end

  initial begin
    step;
    chk("rst_if_req", 32'(if_req), 0);
    chk("rst_if_addr", if_addr, 32'h0);
    chk("rst_fetch_valid", 32'(fetch_valid), 0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_align_fault", 32'(align_fault), 0);
    rst_n = 1'b1;
    if_ack = 1'b1;
    step;
    chk("seq_req", 32'(if_req), 1);
    chk("seq_0", if_addr, 32'h0); q.push_back(32'h0);
    step; chk("seq_4", if_addr, 32'h4); q.push_back(32'h4);
    step; chk("seq_8", if_addr, 32'h8); q.push_back(32'h8);
    step; chk("seq_c", if_addr, 32'hC);
    branch_taken = 1'b1; br_pc_plus4 = 32'h100; branch_offset = 32'hFFFF_FFF0;
    step; branch_taken = 1'b0;
    chk("branch_tgt", if_addr, 32'hF0); q.push_back(32'hF0);
    step; chk("after_branch", if_addr, 32'hF4);
    if_ack = 1'b0; jump_en = 1'b1; jump_index = 26'h40; br_pc_plus4 = 32'h1000_0008;
    step; jump_en = 1'b0;
    chk("hold_addr_1", if_addr, 32'hF4);
    step; chk("hold_addr_2", if_addr, 32'hF4);
    chk("hold_req", 32'(if_req), 1);
    step; chk("hold_addr_3", if_addr, 32'hF4);
    if_ack = 1'b1;
    step; chk("jump_tgt", if_addr, 32'h1000_0100);
    jr_en = 1'b1; jr_target = 32'h2000; branch_taken = 1'b1; br_pc_plus4 = 32'h500; branch_offset = 32'h0;
    step; jr_en = 1'b0; branch_taken = 1'b0;
    chk("jr_wins", if_addr, 32'h2000); q.push_back(32'h2000);
    step; chk("after_jr", if_addr, 32'h2004);
    if_ack = 1'b0;
    step; chk("q_drained_1", 32'(q.size()), 0);

    rst_n = 1'b0;
    step;
    rst_n = 1'b1; if_ack = 1'b1;
    step; chk("s_0", if_addr, 32'h0); q.push_back(32'h0);
    step; chk("s_4", if_addr, 32'h4); q.push_back(32'h4);
    step; chk("s_8", if_addr, 32'h8); q.push_back(32'h8);
    stall = 1'b1;
    step; chk("stall_req_1", 32'(if_req), 0);
    branch_taken = 1'b1; br_pc_plus4 = 32'h40; branch_offset = 32'h0;
    step; branch_taken = 1'b0;
    chk("stall_req_2", 32'(if_req), 0);
    step; chk("stall_req_3", 32'(if_req), 0);
    step; stall = 1'b0;
    chk("stall_req_4", 32'(if_req), 0);
    step; chk("release_req", 32'(if_req), 1);
    chk("release_addr", if_addr, 32'h40); q.push_back(32'h40);
    step; chk("post_release", if_addr, 32'h44);
    jr_en = 1'b1; jr_target = 32'h2002;
    step; jr_en = 1'b0;
    chk("fault_flag", 32'(align_fault), 1);
    chk("fault_req", 32'(if_req), 0);
    chk("fault_addr", if_addr, 32'h44);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("fault_sticky", 32'(align_fault), 1);
      chk("fault_req_low", 32'(if_req), 0);
    end
    chk("q_drained_2", 32'(q.size()), 0);

    rst_n2 = 1'b1; if_ack = 1'b1;
    chk("wrap_rst_addr", if_addr2, 32'hFFFF_FFFC);
    step; chk("wrap_req", 32'(if_req2), 1);
    chk("wrap_first", if_addr2, 32'hFFFF_FFFC);
    step; chk("wrap_second", if_addr2, 32'h0);
    chk("wrap_valid", 32'(fetch_valid2), 1);
    chk("wrap_fetch_pc", fetch_pc2, 32'hFFFF_FFFC);
    #2 rst_n2 = 1'b0;
    #1;
    chk("async_req_drop", 32'(if_req2), 0);
    chk("async_addr", if_addr2, 32'hFFFF_FFFC);
    chk("async_valid", 32'(fetch_valid2), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and instruction-fetch controller for the single-issue core. It consumes the word-aligned branch offset produced by the upstream offset shifter (sign-extended immediate, already shifted left by 2), resolves branch, jump and register-jump redirects, and drives the instruction-memory request port through a req/ack handshake. It holds the architectural fetch PC and squashes words fetched on a path that a later redirect abandons.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- branch_offset  in  32  byte offset from the shifter (offset already <<2).
- br_pc_plus4  in  32  PC+4 of the resolving branch or jump instruction.
- branch_taken  in  1  qualified taken branch this cycle.
- jump_en  in  1  J-type jump this cycle.
- jump_index  in  26  instr[25:0].
- jr_en  in  1  register jump this cycle.
- jr_target  in  32  register value for jr.
- stall  in  1  decode cannot accept a new word.
- if_req  out  1  fetch request.
- if_addr  out  32  fetch address (registered).
- if_ack  in  1  memory returns the word for if_addr this cycle.
- fetch_valid  out  1  fetched word is on the correct path (registered, 1-cycle pulse).
- fetch_pc  out  32  address of the word flagged by fetch_valid.
- align_fault  out  1  sticky misaligned-jr fault.

## Operation
- Target selection, priority jr_en > jump_en > branch_taken:
  - jr: jr_target.
  - jump: {br_pc_plus4[31:28], jump_index, 2'b00}.
  - branch: br_pc_plus4 + branch_offset, modulo 2^32.
  - Otherwise sequential: if_addr + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- FSM states:
  - BOOT: reset state; no request. Moves to REQ on the first clock edge.
  - REQ: if_req=1.
    - ack with stall=0: stay in REQ.
    - ack with stall=1: go to HOLD.
  - HOLD: if_req=0. Returns to REQ on the first cycle with stall=0.
  - FAULT: if_req=0. Left only by reset.
- Redirect handling:
  - A redirect is latched into a pending register (pend_valid, pend_addr). A younger redirect overwrites an older one.
  - A redirect in the same cycle as if_ack, or pending at if_ack, squashes that word: fetch_valid=0.
  - After that ack, the next if_addr is the redirect target and pend_valid clears.
  - A redirect in HOLD updates the next address, applied when HOLD exits; no word is squashed.
- jr_en with jr_target[1:0]!=0:
  - align_fault=1 next cycle.
  - Any outstanding ack is squashed; state goes to FAULT.
  - jr_target is not used.
- Handshake: if_addr stays stable while if_req=1 and if_ack=0. if_ack is ignored when if_req=0.

## Timing
- Reset values: if_req=0, if_addr=RESET_PC, fetch_valid=0, fetch_pc=RESET_PC, align_fault=0, pend_valid=0, state BOOT.
- First request is asserted 1 cycle after rst_n deasserts, with if_addr=RESET_PC.
- Ack in cycle N:
  - fetch_valid and fetch_pc are asserted in N+1.
  - The new if_addr is presented in N+1, so throughput is 1 word/cycle under back-to-back acks.
- Redirect latency: a redirect in cycle N with ack in N gives if_addr = target in N+1. Without an ack, the target is presented on the cycle after the next ack.
- Reset mid-request aborts the request immediately (async). No squash state survives reset.
- stall and redirect in the same cycle: both take effect; the target is held until the stall clears.

## Structure
- Shared package pc_defs: state encodings (BOOT, REQ, HOLD, FAULT), WORD_BYTES=4, default RESET_PC.
- One combinational sub-module, next_pc_sel: redirect priority and target arithmetic. It outputs the redirect flag and target; the FSM, pending register and fetch registers stay in the top module.

## Test plan
- Reset release, ack every cycle, no redirects:
  - if_addr sequence 0x0, 0x4, 0x8, 0xC.
  - fetch_valid high from cycle 2.
- branch_taken with br_pc_plus4=0x100, branch_offset=0xFFFF_FFF0, in the ack cycle:
  - That word is squashed.
  - Next if_addr = 0xF0.
- jump_en with jump_index=0x0000040, br_pc_plus4=0x1000_0008, while ack is withheld 3 cycles:
  - if_addr stays stable.
  - The word returned at ack is squashed.
  - Then if_addr = 0x1000_0100.
- jr_en and branch_taken together, jr_target=0x2000:
  - jr wins; next if_addr = 0x2000.
  - jr_target=0x2002 instead: align_fault=1, if_req=0 until reset.
- stall=1 at ack of 0x8, held 4 cycles, with a branch to 0x40 during the stall:
  - if_req=0 throughout the stall.
  - On release, if_addr = 0x40.
- RESET_PC=0xFFFF_FFFC, ack every cycle:
  - Second address is 0x0000_0000.
  - Reset asserted mid-request: if_req drops with no clock edge needed.
